// File: rtl/jump_logic.sv
// Program-counter load-enable generator: registered en_pc from fetch increment or taken execute-phase jumps.
// Optional macro JUMP_LOGIC_SEL_CHECK_EN adds output_sel_error and suppresses ambiguous multi-select jumps.
module jump_logic (
    input  logic clock,
    input  logic input_clear,
    input  logic input_increment,
    input  logic input_execute,
    input  logic input_jumpz,
    input  logic input_jumpnz,
    input  logic input_jumpc,
    input  logic input_jumpnc,
    input  logic input_jump,
    input  logic input_zero_reg,
    input  logic input_carry_reg,
    output logic output_en_pc
`ifdef JUMP_LOGIC_SEL_CHECK_EN
    ,
    output logic output_sel_error
`endif
);

    logic take;
    logic en_next;

    // Any satisfied condition among the asserted selects takes the jump.
    assign take = input_jump
                | (input_jumpz  &  input_zero_reg)
                | (input_jumpnz & ~input_zero_reg)
                | (input_jumpc  &  input_carry_reg)
                | (input_jumpnc & ~input_carry_reg);

`ifdef JUMP_LOGIC_SEL_CHECK_EN
    logic [4:0] sel_vec;
    logic       multi_sel;
    logic       sel_conflict;

    assign sel_vec = {input_jump, input_jumpz, input_jumpnz, input_jumpc, input_jumpnc};
    // More than one bit set: clear the lowest set bit and see if anything remains.
    assign multi_sel    = |(sel_vec & (sel_vec - 5'd1));
    assign sel_conflict = input_execute & multi_sel;
    assign en_next      = input_increment | (input_execute & take & ~sel_conflict);

    always_ff @(posedge clock or posedge input_clear) begin
        if (input_clear) begin
            output_sel_error <= 1'b0;
        end else begin
            output_sel_error <= sel_conflict;
        end
    end
`else
    assign en_next = input_increment | (input_execute & take);
`endif

    always_ff @(posedge clock or posedge input_clear) begin
        if (input_clear) begin
            output_en_pc <= 1'b0;
        end else begin
            output_en_pc <= en_next;
        end
    end

endmodule

// File: tb/tb_jump_logic.sv
// Directed self-checking bench for jump_logic; honours JUMP_LOGIC_SEL_CHECK_EN when defined.
module tb_jump_logic;

    logic clock = 1'b0;
    logic input_clear;
    logic input_increment;
    logic input_execute;
    logic input_jumpz;
    logic input_jumpnz;
    logic input_jumpc;
    logic input_jumpnc;
    logic input_jump;
    logic input_zero_reg;
    logic input_carry_reg;
    logic output_en_pc;
`ifdef JUMP_LOGIC_SEL_CHECK_EN
    logic output_sel_error;
`endif

    int checks = 0;
    int failures = 0;

    jump_logic dut (
        .clock           (clock),
        .input_clear     (input_clear),
        .input_increment (input_increment),
        .input_execute   (input_execute),
        .input_jumpz     (input_jumpz),
        .input_jumpnz    (input_jumpnz),
        .input_jumpc     (input_jumpc),
        .input_jumpnc    (input_jumpnc),
        .input_jump      (input_jump),
        .input_zero_reg  (input_zero_reg),
        .input_carry_reg (input_carry_reg),
        .output_en_pc    (output_en_pc)
`ifdef JUMP_LOGIC_SEL_CHECK_EN
        ,
        .output_sel_error(output_sel_error)
`endif
    );

    always #5 clock = ~clock;

    task automatic check_output(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Drive a full input vector on the falling edge, away from the sampling edge.
    task automatic apply_stimulus(input logic inc, input logic exe,
                                  input logic jz, input logic jnz,
                                  input logic jc, input logic jnc, input logic j,
                                  input logic z, input logic c);
        @(negedge clock);
        input_increment = inc;
        input_execute   = exe;
        input_jumpz     = jz;
        input_jumpnz    = jnz;
        input_jumpc     = jc;
        input_jumpnc    = jnc;
        input_jump      = j;
        input_zero_reg  = z;
        input_carry_reg = c;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Apply a vector, clock it in, and check en_pc one edge later.
    task automatic step_check(input string tag, input logic inc, input logic exe,
                              input logic jz, input logic jnz,
                              input logic jc, input logic jnc, input logic j,
                              input logic z, input logic c, input logic exp_en);
        apply_stimulus(inc, exe, jz, jnz, jc, jnc, j, z, c);
        tick();
        check_output(tag, output_en_pc, exp_en);
    endtask

    initial begin
        input_clear = 1'b1;
        input_increment = 1'b1;
        input_execute = 1'b0;
        input_jumpz = 1'b0;
        input_jumpnz = 1'b0;
        input_jumpc = 1'b0;
        input_jumpnc = 1'b0;
        input_jump = 1'b0;
        input_zero_reg = 1'b0;
        input_carry_reg = 1'b0;

        // Reset held with increment requested: output must stay low across edges.
        #1;
        check_output("reset_initial", output_en_pc, 1'b0);
        tick();
        check_output("reset_held_edge1", output_en_pc, 1'b0);
        apply_stimulus(1, 1, 0, 0, 0, 0, 1, 0, 0);
        tick();
        check_output("reset_held_edge2", output_en_pc, 1'b0);
`ifdef JUMP_LOGIC_SEL_CHECK_EN
        check_output("reset_sel_error", output_sel_error, 1'b0);
`endif

        // Release reset, then increment raises en_pc after the next edge.
        @(negedge clock);
        input_clear = 1'b0;
        #1;
        check_output("release_no_edge", output_en_pc, 1'b0);
        step_check("increment", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1);

        // Asynchronous clear mid-cycle while en_pc is high.
        #2;
        input_clear = 1'b1;
        #1;
        check_output("async_clear", output_en_pc, 1'b0);
        @(negedge clock);
        input_clear = 1'b0;
        #1;
        check_output("clear_release_hold", output_en_pc, 1'b0);

        step_check("jz_taken",       0, 1, 1, 0, 0, 0, 0, 1, 0, 1'b1);
        step_check("jz_not_taken",   0, 1, 1, 0, 0, 0, 0, 0, 0, 1'b0);
        step_check("jnz_taken",      0, 1, 0, 1, 0, 0, 0, 0, 0, 1'b1);
        step_check("all_zero",       0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
        step_check("jnz_not_taken",  0, 1, 0, 1, 0, 0, 0, 1, 0, 1'b0);
        step_check("jc_no_execute",  0, 0, 0, 0, 1, 0, 0, 0, 1, 1'b0);
        step_check("jnc_no_execute", 0, 0, 0, 0, 0, 1, 0, 0, 0, 1'b0);
        step_check("jc_taken",       0, 1, 0, 0, 1, 0, 0, 0, 1, 1'b1);
        step_check("jc_not_taken",   0, 1, 0, 0, 1, 0, 0, 0, 0, 1'b0);
        step_check("jnc_taken",      0, 1, 0, 0, 0, 1, 0, 0, 0, 1'b1);
        step_check("jnc_not_taken",  0, 1, 0, 0, 0, 1, 0, 0, 1, 1'b0);
        step_check("execute_only",   0, 1, 0, 0, 0, 0, 0, 1, 1, 1'b0);
        step_check("jump_no_exec",   0, 0, 0, 0, 0, 0, 1, 1, 1, 1'b0);
        step_check("jump_flags_00",  0, 1, 0, 0, 0, 0, 1, 0, 0, 1'b1);
        step_check("jump_flags_11",  0, 1, 0, 0, 0, 0, 1, 1, 1, 1'b1);
        step_check("inc_plus_jump",  1, 1, 1, 0, 0, 0, 0, 1, 0, 1'b1);
        step_check("inc_failed_jz",  1, 1, 1, 0, 0, 0, 0, 0, 0, 1'b1);

        // Two selects together: ORed by default, suppressed with the check enabled.
`ifdef JUMP_LOGIC_SEL_CHECK_EN
        step_check("multi_sel_en", 0, 1, 1, 0, 1, 0, 0, 1, 0, 1'b0);
        check_output("multi_sel_error", output_sel_error, 1'b1);
        step_check("multi_sel_inc", 1, 1, 1, 0, 1, 0, 0, 1, 0, 1'b1);
        check_output("multi_sel_error_inc", output_sel_error, 1'b1);
        step_check("multi_sel_no_exec", 0, 0, 1, 0, 1, 0, 0, 1, 0, 1'b0);
        check_output("multi_sel_error_noexec", output_sel_error, 1'b0);
        step_check("single_sel", 0, 1, 1, 0, 0, 0, 0, 1, 0, 1'b1);
        check_output("single_sel_error", output_sel_error, 1'b0);
`else
        step_check("multi_sel_en", 0, 1, 1, 0, 1, 0, 0, 1, 0, 1'b1);
        step_check("multi_sel_unsat", 0, 1, 1, 0, 1, 0, 0, 0, 0, 1'b0);
        step_check("multi_sel_one_sat", 0, 1, 0, 1, 1, 0, 0, 1, 1, 1'b1);
`endif

        step_check("final_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jump_logic.md
Name: jump_logic

Overview:
- Program-counter load-enable generator for the 8-bit CPU decoder.
- Combines the fetch-phase increment request with the execute-phase conditional/unconditional jump selects, evaluated against the registered ALU zero and carry flags.
- Drives en_pc to the program counter.
- en_pc is registered: one clock of latency, asynchronously cleared.

Parameters:
- None. All widths are fixed at 1 bit.

Ports:
- clock  in  1  system clock; rising edge active
- input_clear  in  1  reset; asynchronous, active-high
- input_increment  in  1  fetch-phase PC advance request
- input_execute  in  1  execute-phase strobe; qualifies all jump selects
- input_jumpz  in  1  jump if zero flag = 1
- input_jumpnz  in  1  jump if zero flag = 0
- input_jumpc  in  1  jump if carry flag = 1
- input_jumpnc  in  1  jump if carry flag = 0
- input_jump  in  1  unconditional jump
- input_zero_reg  in  1  registered ALU zero flag
- input_carry_reg  in  1  registered ALU carry flag
- output_en_pc  out  1  PC enable, registered

Behaviour:
- Reset:
  - input_clear = 1 forces output_en_pc = 0 immediately, independent of clock.
  - While input_clear is held, output_en_pc stays 0 and all other inputs are ignored.
  - Deassertion takes effect at the next rising edge.
- Condition term: take = jump OR (jumpz AND zero_reg) OR (jumpnz AND NOT zero_reg) OR (jumpc AND carry_reg) OR (jumpnc AND NOT carry_reg).
- Next value: en_next = increment OR (execute AND take).
- Register update: on each rising clock edge with clear = 0, output_en_pc <= en_next.
- Latency: inputs sampled at edge N appear on output_en_pc after edge N; the output holds until the next edge.
- Jump selects with execute = 0 have no effect on en_next. Only increment can raise en_pc outside execute.
- Multiple jump selects asserted together: their conditions are ORed, so any satisfied condition is taken (unless the optional feature below is compiled in).
- increment and a taken jump in the same cycle: en_next = 1. The output does not distinguish load from increment; the PC mux selects separately.
- Flags are used as presented at the sampling edge. There is no internal flag storage.
- No X-propagation masking. All inputs must be driven once clear is deasserted.

Optional Feature:
- Macro: JUMP_LOGIC_SEL_CHECK_EN
- With the macro defined:
  - Extra output port output_sel_error (out, 1), registered, reset to 0.
  - On any edge where execute = 1 and more than one of {jump, jumpz, jumpnz, jumpc, jumpnc} is 1:
    - output_sel_error <= 1.
    - The jump contribution is suppressed: en_next = increment only.
  - Otherwise output_sel_error <= 0.
- Without the macro: the port is absent and selects are ORed as described in Behaviour.

Test Plan:
- Reset: clear = 1 with increment = 1, then toggle the clock -> en_pc = 0 throughout. Assert clear mid-cycle while en_pc = 1 -> en_pc drops to 0 without a clock edge.
- JZ taken: execute = 1, jumpz = 1, zero_reg = 1 -> en_pc = 1 after next edge. With zero_reg = 0 -> en_pc = 0.
- JNZ taken: execute = 1, jumpnz = 1, zero_reg = 0 -> en_pc = 1. Next cycle all inputs 0 -> en_pc = 0.
- Execute gating: jumpc = 1, carry_reg = 1, execute = 0 -> en_pc = 0. Likewise jumpnc = 1, carry_reg = 0, execute = 0 -> en_pc = 0. Repeat both with execute = 1 -> en_pc = 1.
- Increment: increment = 1, all else 0 -> en_pc = 1 one edge later. Unconditional jump = 1 with execute = 1 and flags in any state -> en_pc = 1.
- Optional (JUMP_LOGIC_SEL_CHECK_EN): execute = 1, jumpz = 1, jumpc = 1, zero_reg = 1, increment = 0 -> sel_error = 1 and en_pc = 0. Without the macro, the same stimulus gives en_pc = 1.
